// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul_sched
// Purpose  : Round-robin scheduler that shares one sequential add-shift
//            multiplier among N_REQ requesters. It sequences the multiplier's
//            en/done protocol, returns tagged results on a single response
//            channel and aborts an operation whose done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sched #(
    parameter  int DATA_W = 32,
    parameter  int N_REQ  = 4,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_sign,
    input  logic [N_REQ*DATA_W-1:0]   req_op_a,
    input  logic [N_REQ*DATA_W-1:0]   req_op_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [2*DATA_W-1:0]       rsp_product,
    output logic                      rsp_err,
    output logic                      mul_en,
    output logic                      mul_sign,
    output logic [DATA_W-1:0]         mul_op_a,
    output logic [DATA_W-1:0]         mul_op_b,
    input  logic                      mul_done,
    input  logic [2*DATA_W-1:0]       mul_product
);

    // run_cnt must reach DATA_W+1, the last cycle a late done is still waited for
    localparam int              RUN_W    = $clog2(DATA_W + 3);
    localparam logic [RUN_W-1:0] WD_LIMIT = RUN_W'(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     last;
    logic [RUN_W-1:0]    run_cnt;

    logic [2*N_REQ-1:0]  rot;
    logic                any_req;
    logic [ID_W-1:0]     winner;
    int                  pos;
    int                  tgt;

    logic                sel_sign;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    // Round-robin pick: rotate so that last+1 sits at bit 0, take the lowest
    // set bit, then map that offset back to an absolute requester index.
    always_comb begin
        rot     = {req_valid, req_valid} >> ({1'b0, last} + (ID_W+1)'(1));
        pos     = 0;
        any_req = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos     = i;
                any_req = 1'b1;
            end
        end
        tgt = int'(last) + 1 + pos;
        if (tgt >= N_REQ) begin
            tgt = tgt - N_REQ;
        end
        winner = ID_W'(tgt);
    end

    // Grant is combinational so the requester sees acceptance in the same cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = rst_n && (state == IDLE) && any_req && (winner == ID_W'(i));
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_sign = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_sign = req_sign[i];
                sel_a    = req_op_a[i*DATA_W +: DATA_W];
                sel_b    = req_op_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM with all datapath and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= ID_W'(N_REQ - 1);
            run_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            mul_en      <= 1'b0;
            mul_sign    <= 1'b0;
            mul_op_a    <= '0;
            mul_op_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mul_sign <= sel_sign;
                        mul_op_a <= sel_a;
                        mul_op_b <= sel_b;
                        rsp_id   <= winner;
                        last     <= winner;
                        run_cnt  <= '0;
                        mul_en   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + RUN_W'(1);
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        mul_en      <= 1'b0;
                        state       <= RESP;
                    end else if (run_cnt == WD_LIMIT) begin
                        // Multiplier overdue: report an error with a zero product
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        mul_en      <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
